// File: rtl/axi4_pkg.sv
// ============================================================================
// axi4_pkg: shared AXI4 response codes, responder FSM states and helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi4_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // 16-bit counter add that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_default_slave_rd.sv
// ============================================================================
// axi4_default_slave_rd: read-side responder, returns arlen+1 zero DECERR beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi4_default_slave_rd
  import axi4_pkg::*;
#(
  parameter int ID_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ID_WIDTH-1:0]  arid,
  input  logic [AXI_LEN_W-1:0] arlen,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [ID_WIDTH-1:0]  rid,
  output logic                 rlast,
  output logic                 rvalid,
  input  logic                 rready
);

  rd_state_t            state_q;
  logic [AXI_LEN_W-1:0] beat_cnt_q;
  logic                 arready_q;
  logic                 rvalid_q;
  logic                 rlast_q;
  logic [ID_WIDTH-1:0]  rid_q;

  // rlast is precomputed one beat ahead so it is a flop output, equal to (beat_cnt == 0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= R_IDLE;
      beat_cnt_q <= '0;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            rid_q      <= arid;
            beat_cnt_q <= arlen;
            rlast_q    <= (arlen == '0);
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            state_q    <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= R_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q - 1'b1;
              rlast_q    <= (beat_cnt_q == AXI_LEN_W'(1));
            end
          end
        end
        default: begin
          state_q   <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;

endmodule

`default_nettype wire

// File: rtl/axi4_default_slave.sv
// ============================================================================
// axi4_default_slave: DECERR responder for undecoded AXI4 accesses.
// Optional error log enabled by defining AXI4_DEFAULT_SLAVE_LOG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi4_default_slave
  import axi4_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef AXI4_DEFAULT_SLAVE_LOG_EN
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic                    err_is_wr,
  output logic [15:0]             err_cnt,
`endif
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [AXI_LEN_W-1:0]    awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [AXI_LEN_W-1:0]    arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  wr_state_t           wr_state_q;
  logic                awready_q;
  logic                wready_q;
  logic                bvalid_q;
  logic [ID_WIDTH-1:0] bid_q;
  logic                aw_hs;

  assign aw_hs = awvalid && awready_q;

  // Write path: one AW at a time, W beats drained until wlast regardless of awlen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            bid_q      <= awid;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready_q && wlast) begin
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            wr_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          wr_state_q <= W_IDLE;
          awready_q  <= 1'b1;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = RESP_DECERR;

  axi4_default_slave_rd #(
    .ID_WIDTH (ID_WIDTH)
  ) u_rd (
    .clk     (clk),
    .rst_n   (rst_n),
    .arid    (arid),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  assign rdata = '0;
  assign rresp = RESP_DECERR;

`ifdef AXI4_DEFAULT_SLAVE_LOG_EN
  logic                  ar_hs;
  logic [1:0]            log_inc;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic                  err_is_wr_q;
  logic [15:0]           err_cnt_q;
  logic [15:0]           err_cnt_d;

  assign ar_hs     = arvalid && arready;
  assign log_inc   = {1'b0, aw_hs} + {1'b0, ar_hs};
  assign err_cnt_d = sat_add16(err_cnt_q, log_inc);

  // A simultaneous AW and AR logs the write address but counts both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_q  <= '0;
      err_is_wr_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (aw_hs) begin
        err_addr_q  <= awaddr;
        err_is_wr_q <= 1'b1;
      end else if (ar_hs) begin
        err_addr_q  <= araddr;
        err_is_wr_q <= 1'b0;
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_is_wr = err_is_wr_q;
  assign err_cnt   = err_cnt_q;

  logic unused_ok;
  assign unused_ok = ^{awlen, wdata, wstrb};
`else
  logic unused_ok;
  assign unused_ok = ^{awaddr, araddr, awlen, wdata, wstrb};
`endif

endmodule

`default_nettype wire
